regfile_wb_queue: RTL and testbench

- Writeback-side driver for the processor register file's write port: data, write address, write enable.
- Accepts write requests from two producers: the ALU result path and the multi-cycle memory/load path.
- Buffers requests in a small in-order FIFO and drains one write per cycle.
- Reports pending-write hazards to decode so it can stall on a register whose new value has not yet been committed.

---
 rtl/regfile_wb_queue_pkg.sv | 14 +
 rtl/regfile_wb_queue_if.sv | 60 ++++++
 rtl/regfile_wb_queue_wb_fifo.sv | 52 +++++
 rtl/regfile_wb_queue.sv | 137 +++++++++++++
 tb/tb_regfile_wb_queue.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_queue_pkg.sv
// Shared defaults and entry layout for the register-file writeback queue.
// Combinational only; no latency or backpressure of its own.
package regfile_wb_pkg;

  localparam int WB_WIDTH  = 32;
  localparam int WB_ADDR_W = 5;
  localparam int REG_ZERO  = 0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_WIDTH-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Producer, register-file and decode-check bundle for the writeback queue.
// Optional fwd* signals exist only with REGFILE_WB_FORWARD_EN.
interface regfile_wb_queue_if import regfile_wb_pkg::*; #(
  parameter int WIDTH  = WB_WIDTH,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 4
);

  logic                       alu_valid;
  logic                       alu_ready;
  logic [ADDR_W-1:0]          alu_addr;
  logic [WIDTH-1:0]           alu_data;
  logic                       mem_valid;
  logic                       mem_ready;
  logic [ADDR_W-1:0]          mem_addr;
  logic [WIDTH-1:0]           mem_data;
  logic                       rf_we;
  logic [ADDR_W-1:0]          rf_waddr;
  logic [WIDTH-1:0]           rf_wdata;
  logic [ADDR_W-1:0]          chk_addr1;
  logic [ADDR_W-1:0]          chk_addr2;
  logic                       hazard1;
  logic                       hazard2;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       empty;
  logic                       full;
`ifdef REGFILE_WB_FORWARD_EN
  logic                       fwd1_valid;
  logic                       fwd2_valid;
  logic [WIDTH-1:0]           fwd1_data;
  logic [WIDTH-1:0]           fwd2_data;
`endif

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  chk_addr1, chk_addr2,
    output alu_ready, mem_ready,
    output rf_we, rf_waddr, rf_wdata,
    output hazard1, hazard2,
    output count, empty, full
`ifdef REGFILE_WB_FORWARD_EN
    , output fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
`endif
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output chk_addr1, chk_addr2,
    input  alu_ready, mem_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  hazard1, hazard2,
    input  count, empty, full
`ifdef REGFILE_WB_FORWARD_EN
    , input fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
`endif
  );

endinterface

// File: rtl/regfile_wb_queue_wb_fifo.sv
// In-order storage with 0/1/2 pushes and 0/1 pop per cycle; entries exposed oldest-first.
// Head visible combinationally; caller must never push beyond free space.
module wb_fifo #(
  parameter int ENTRY_W = 37,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 pushCnt,
  input  logic [ENTRY_W-1:0]         push0Dat,
  input  logic [ENTRY_W-1:0]         push1Dat,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [ENTRY_W-1:0]         headDat,
  output logic [ENTRY_W-1:0]         ordDat [DEPTH],
  output logic                       ordVld [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ENTRY_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   wrPtr;
  logic [CNT_W-1:0]   cnt;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      cnt   <= '0;
    end else begin
      if (pushCnt != 2'd0) store[wrPtr] <= push0Dat;
      if (pushCnt == 2'd2) store[wrPtr + PTR_W'(1)] <= push1Dat;
      wrPtr <= wrPtr + PTR_W'(pushCnt);
      if (pop) rdPtr <= rdPtr + PTR_W'(1);
      cnt <= cnt + CNT_W'(pushCnt) - CNT_W'(pop);
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ordDat[k] = store[rdPtr + PTR_W'(k)];
      ordVld[k] = (k < int'(cnt));
    end
  end

  assign headDat = store[rdPtr];
  assign count   = cnt;

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue driving the register-file write port from ALU and load producers.
// Latency: accept at edge N, rf_* valid after edge N+1. Ready drops when free slots run out (load wins the last slot).
// Optional forwarding outputs: REGFILE_WB_FORWARD_EN.
module regfile_wb_queue import regfile_wb_pkg::*; #(
  parameter int WIDTH  = WB_WIDTH,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  regfile_wb_queue_if.slave  bus
);

  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = ADDR_W + WIDTH;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } entry_t;

  function automatic logic isRegZero(input logic [ADDR_W-1:0] a);
    return a == ADDR_W'(REG_ZERO);
  endfunction

  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   free;
  logic               memReady;
  logic               aluReady;
  logic               memPush;
  logic               aluPush;
  logic               pop;
  logic [1:0]         pushCnt;
  entry_t             memEntry;
  entry_t             aluEntry;
  entry_t             push0;
  entry_t             head;
  logic [ENTRY_W-1:0] headDat;
  logic [ENTRY_W-1:0] ordDat [DEPTH];
  logic               ordVld [DEPTH];
  entry_t             ordEntry [DEPTH];

  // Free space ignores this cycle's pop, so a full queue never accepts on the drain edge.
  assign free     = CNT_W'(DEPTH) - count;
  assign memReady = !rst && (free != '0);
  assign aluReady = !rst && ((free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !bus.mem_valid));

  // Writes to r0 complete the handshake but never occupy a slot.
  assign memPush  = bus.mem_valid && memReady && !isRegZero(bus.mem_addr);
  assign aluPush  = bus.alu_valid && aluReady && !isRegZero(bus.alu_addr);
  assign pushCnt  = {1'b0, memPush} + {1'b0, aluPush};
  assign pop      = (count != '0);

  assign memEntry = '{addr: bus.mem_addr, data: bus.mem_data};
  assign aluEntry = '{addr: bus.alu_addr, data: bus.alu_data};
  assign push0    = memPush ? memEntry : aluEntry;

  wb_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) fifo (
    .clk      (clk),
    .rst      (rst),
    .pushCnt  (pushCnt),
    .push0Dat (push0),
    .push1Dat (aluEntry),
    .pop      (pop),
    .count    (count),
    .headDat  (headDat),
    .ordDat   (ordDat),
    .ordVld   (ordVld)
  );

  assign head = headDat;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else if (pop) begin
      bus.rf_we    <= 1'b1;
      bus.rf_waddr <= head.addr;
      bus.rf_wdata <= head.data;
    end else begin
      bus.rf_we    <= 1'b0;
    end
  end

  logic [ADDR_W-1:0] chkAddr [2];
  logic              hit [2];
`ifdef REGFILE_WB_FORWARD_EN
  logic [WIDTH-1:0]  youngest [2];
`endif

  // The in-flight rf_* write counts as pending until the register file has sampled it.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) ordEntry[k] = ordDat[k];
    chkAddr[0] = bus.chk_addr1;
    chkAddr[1] = bus.chk_addr2;
    for (int j = 0; j < 2; j++) begin
      hit[j] = bus.rf_we && (bus.rf_waddr == chkAddr[j]);
`ifdef REGFILE_WB_FORWARD_EN
      youngest[j] = bus.rf_wdata;
`endif
      for (int k = 0; k < DEPTH; k++) begin
        if (ordVld[k] && (ordEntry[k].addr == chkAddr[j])) begin
          hit[j] = 1'b1;
`ifdef REGFILE_WB_FORWARD_EN
          youngest[j] = ordEntry[k].data;
`endif
        end
      end
      if (isRegZero(chkAddr[j])) hit[j] = 1'b0;
    end
  end

`ifdef REGFILE_WB_FORWARD_EN
  // Every pending value is forwardable, so decode never needs to stall.
  assign bus.hazard1    = 1'b0;
  assign bus.hazard2    = 1'b0;
  assign bus.fwd1_valid = hit[0];
  assign bus.fwd2_valid = hit[1];
  assign bus.fwd1_data  = youngest[0];
  assign bus.fwd2_data  = youngest[1];
`else
  assign bus.hazard1    = hit[0];
  assign bus.hazard2    = hit[1];
`endif

  assign bus.alu_ready = aluReady;
  assign bus.mem_ready = memReady;
  assign bus.count     = count;
  assign bus.empty     = (count == '0);
  assign bus.full      = (count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed plus random bench for regfile_wb_queue against a queue-based reference model.
module tb_regfile_wb_queue;
  import regfile_wb_pkg::*;

  localparam int DEPTH = 4;
`ifdef REGFILE_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_queue_if #(.WIDTH(WB_WIDTH), .ADDR_W(WB_ADDR_W), .DEPTH(DEPTH)) bus ();

  regfile_wb_queue #(.WIDTH(WB_WIDTH), .ADDR_W(WB_ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wb_entry_t              q[$];
  logic                   mWe   = 1'b0;
  logic [WB_ADDR_W-1:0]   mAddr = '0;
  logic [WB_WIDTH-1:0]    mData = '0;
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic expHaz(input logic [WB_ADDR_W-1:0] a);
    if (a == 0) return 1'b0;
    if (mWe && mAddr == a) return 1'b1;
    foreach (q[i]) if (q[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [WB_WIDTH-1:0] expFwd(input logic [WB_ADDR_W-1:0] a);
    logic [WB_WIDTH-1:0] d = mData;
    foreach (q[i]) if (q[i].addr == a) d = q[i].data;
    return d;
  endfunction

  task automatic drive(input logic mv, input logic [WB_ADDR_W-1:0] ma, input logic [WB_WIDTH-1:0] md,
                       input logic av, input logic [WB_ADDR_W-1:0] aa, input logic [WB_WIDTH-1:0] ad,
                       input logic [WB_ADDR_W-1:0] c1, input logic [WB_ADDR_W-1:0] c2);
    bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.chk_addr1 = c1; bus.chk_addr2 = c2;
  endtask

  // Called just after a negedge with inputs applied; checks, then advances one clock.
  task automatic step(input string tag);
    int freeSlots;
    logic expMem, expAlu, memAcc, aluAcc;
    wb_entry_t mE, aE, h;
    #1;
    freeSlots = DEPTH - q.size();
    expMem = !rst && freeSlots >= 1;
    expAlu = !rst && (freeSlots >= 2 || (freeSlots == 1 && !bus.mem_valid));
    check({tag, ".count"},     bus.count,     q.size());
    check({tag, ".empty"},     bus.empty,     q.size() == 0);
    check({tag, ".full"},      bus.full,      q.size() == DEPTH);
    check({tag, ".rf_we"},     bus.rf_we,     mWe);
    check({tag, ".rf_waddr"},  bus.rf_waddr,  mAddr);
    check({tag, ".rf_wdata"},  bus.rf_wdata,  mData);
    check({tag, ".mem_ready"}, bus.mem_ready, expMem);
    check({tag, ".alu_ready"}, bus.alu_ready, expAlu);
    check({tag, ".hazard1"},   bus.hazard1,   FWD ? 1'b0 : expHaz(bus.chk_addr1));
    check({tag, ".hazard2"},   bus.hazard2,   FWD ? 1'b0 : expHaz(bus.chk_addr2));
`ifdef REGFILE_WB_FORWARD_EN
    check({tag, ".fwd1_valid"}, bus.fwd1_valid, expHaz(bus.chk_addr1));
    check({tag, ".fwd2_valid"}, bus.fwd2_valid, expHaz(bus.chk_addr2));
    if (expHaz(bus.chk_addr1)) check({tag, ".fwd1_data"}, bus.fwd1_data, expFwd(bus.chk_addr1));
    if (expHaz(bus.chk_addr2)) check({tag, ".fwd2_data"}, bus.fwd2_data, expFwd(bus.chk_addr2));
`endif
    memAcc = bus.mem_valid && expMem;
    aluAcc = bus.alu_valid && expAlu;
    mE = '{addr: bus.mem_addr, data: bus.mem_data};
    aE = '{addr: bus.alu_addr, data: bus.alu_data};
    @(posedge clk);
    if (rst) begin
      q.delete();
      mWe = 1'b0; mAddr = '0; mData = '0;
    end else begin
      if (q.size() > 0) begin
        h = q.pop_front();
        mWe = 1'b1; mAddr = h.addr; mData = h.data;
      end else begin
        mWe = 1'b0;
      end
      if (memAcc && mE.addr != 0) q.push_back(mE);
      if (aluAcc && aE.addr != 0) q.push_back(aE);
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset with both producers requesting.
    rst = 1'b1;
    drive(1'b1, 5'd7, 32'h7, 1'b1, 5'd8, 32'h8, 5'd7, 5'd8);
    @(posedge clk);
    @(negedge clk);
    step("rst0");
    step("rst1");
    check("rst.empty", bus.empty, 1'b1);
    rst = 1'b0;

    // Single ALU write to r3.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd0);
    step("single_acc");
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
    #1;
    check("single.haz_queued", bus.hazard1, FWD ? 1'b0 : 1'b1);
    step("single_q");
    check("single.rf_we",    bus.rf_we,    1'b1);
    check("single.rf_waddr", bus.rf_waddr, 5'd3);
    check("single.rf_wdata", bus.rf_wdata, 32'hDEADBEEF);
    check("single.haz_flight", bus.hazard1, FWD ? 1'b0 : 1'b1);
    step("single_commit");
    check("single.rf_we_off", bus.rf_we, 1'b0);

    // Dual push to the same register: load is older.
    drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 5'd5, 5'd6);
    step("dual_acc");
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
    check("dual.count", bus.count, 3'd2);
    step("dual_q");
    check("dual.first", bus.rf_wdata, 32'h11);
    step("dual_d1");
    check("dual.second", bus.rf_wdata, 32'h22);
    check("dual.second_we", bus.rf_we, 1'b1);
    step("dual_d2");

    // Streaming from both producers until free space runs out.
    drive(1'b1, 5'd9, 32'hA1, 1'b1, 5'd10, 32'hA2, 5'd9, 5'd10);
    step("bp0");
    drive(1'b1, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hB2, 5'd11, 5'd12);
    step("bp1");
    drive(1'b1, 5'd13, 32'hC1, 1'b1, 5'd14, 32'hC2, 5'd13, 5'd14);
    #1;
    check("bp.count3",   bus.count,     3'd3);
    check("bp.mem_prio", bus.mem_ready, 1'b1);
    check("bp.alu_held", bus.alu_ready, 1'b0);
    step("bp2");
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hC2, 5'd14, 5'd13);
    #1;
    check("bp.alu_last_slot", bus.alu_ready, 1'b1);
    step("bp3");
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd13, 5'd14);
    for (int i = 0; i < 5; i++) step("bp_drain");

    // Register zero: handshake completes, nothing queued.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55, 5'd0, 5'd0);
    #1;
    check("r0.alu_ready", bus.alu_ready, 1'b1);
    step("r0_acc");
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    check("r0.count", bus.count, 3'd0);
    step("r0_after");
    check("r0.rf_we", bus.rf_we, 1'b0);
    check("r0.hazard1", bus.hazard1, 1'b0);

    // Reset in the middle of a drain.
    drive(1'b1, 5'd20, 32'hD1, 1'b1, 5'd21, 32'hD2, 5'd20, 5'd21);
    step("mid_fill0");
    drive(1'b1, 5'd22, 32'hD3, 1'b1, 5'd23, 32'hD4, 5'd22, 5'd23);
    step("mid_fill1");
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd22, 5'd23);
    step("mid_rst");
    rst = 1'b0;
    check("mid.count", bus.count, 3'd0);
    check("mid.rf_we", bus.rf_we, 1'b0);
    for (int i = 0; i < 4; i++) step("mid_idle");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
